apb_completer_mem: RTL

//  APB3/APB4 completer (slave) with DEPTH x DATA_WIDTH register/memory storage.
//  It is the responder the APB master VIP drives in integration benches: it answers

---
 rtl/apb_completer_mem_if.sv | 26 ++
 rtl/apb_completer_mem.sv | 112 +++++++++++
 2 files changed

// File: rtl/apb_completer_mem_if.sv
// APB3/APB4 completer bus bundle: master drives the request side, slave answers
// with PREADY/PRDATA/PSLVERR.
interface apb_completer_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_completer_mem.sv
// APB completer with DEPTH x DATA_WIDTH storage, programmable wait states and
// PSLVERR on out-of-range/misaligned access. APB_COMP_PSTRB_EN enables byte strobes.
module apb_completer_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_completer_mem_if.slave  bus
);
  localparam int BW   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BW);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            wcnt;
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx_in;
  logic [IW-1:0]         idx_lo;
  logic                  misalign;
  logic                  range_err;
  logic                  strb_err;
  logic                  setup_err;
  logic                  ready;

  assign idx_in    = bus.PADDR >> OFFW;
  assign idx_lo    = idx_in[IW-1:0];
  assign misalign  = |(bus.PADDR & ADDR_WIDTH'(BW - 1));
  assign range_err = 32'(idx_in) >= 32'(DEPTH);

`ifdef APB_COMP_PSTRB_EN
  logic [BW-1:0] strb_q;
  // Strobes on a read are illegal in APB4 and reported as an error.
  assign strb_err = !bus.PWRITE && (bus.PSTRB != '0);
`else
  logic unused_pstrb;
  assign unused_pstrb = ^bus.PSTRB;
  assign strb_err     = 1'b0;
`endif

  assign setup_err = range_err || misalign || strb_err;

  // Completion is decided purely by state/wcnt so PREADY needs no extra register.
  assign ready       = (state == ACCESS) && (wcnt == '0);
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_q;
  assign bus.PRDATA  = (ready && !wr_q && !err_q) ? rdata_q : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      wcnt    <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef APB_COMP_PSTRB_EN
      strb_q  <= '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IW'(i)] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            idx_q   <= idx_lo;
            wr_q    <= bus.PWRITE;
            err_q   <= setup_err;
            wdata_q <= bus.PWDATA;
            rdata_q <= setup_err ? '0 : mem[idx_lo];
            wcnt    <= 4'(WAIT_CYCLES);
`ifdef APB_COMP_PSTRB_EN
            strb_q  <= bus.PSTRB;
`endif
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            state <= IDLE;
          end else if (wcnt != '0) begin
            if (bus.PENABLE) wcnt <= wcnt - 4'd1;
          end else begin
            state <= IDLE;
            if (wr_q && !err_q) begin
`ifdef APB_COMP_PSTRB_EN
              for (int unsigned b = 0; b < BW; b++) begin
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
              end
`else
              mem[idx_q] <= wdata_q;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
